// File: rtl/psi_chunk_sched.sv
// Chunked bitmap private-set-intersection sequencer: ANDs N party bitmaps arriving
// C bits at a time into a W-bit accumulator, then streams the result and its popcount.
module psi_chunk_sched #(
    parameter int N     = 4,
    parameter int W     = 16,
    parameter int C     = 4,
    parameter int CNT_W = $clog2(W + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [C-1:0]     in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [C-1:0]     out_data,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] card
);
    localparam int K  = W / C;
    localparam int KW = (K > 1) ? $clog2(K) : 1;
    localparam int PW = $clog2(N);

    typedef enum logic [1:0] {IDLE, LOAD, DRAIN} state_t;

    state_t            state, state_nxt;
    logic [KW-1:0]     k;
    logic [PW-1:0]     p;
    logic [C-1:0]      acc [K];
    logic              k_last, p_last;
    logic              in_xfer, out_hs, run_go;
    logic [CNT_W-1:0]  chunk_pop;

    assign k_last = (k == KW'(K - 1));
    assign p_last = (p == PW'(N - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // abort wins over any handshake in the same cycle
    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        in_xfer   = 1'b0;
        out_hs    = 1'b0;
        run_go    = 1'b0;
        case (state)
            IDLE: begin
                if (start && !abort) begin
                    run_go    = 1'b1;
                    state_nxt = LOAD;
                end
            end
            LOAD: begin
                in_ready = 1'b1;
                busy     = 1'b1;
                in_xfer  = in_valid && !abort;
                if (abort)                              state_nxt = IDLE;
                else if (in_xfer && p_last && k_last)   state_nxt = DRAIN;
            end
            DRAIN: begin
                out_valid = 1'b1;
                busy      = 1'b1;
                out_hs    = out_ready && !abort;
                if (abort)                  state_nxt = IDLE;
                else if (out_hs && k_last)  state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign out_data = (state == DRAIN) ? acc[k] : '0;

    always_comb begin
        chunk_pop = '0;
        for (int i = 0; i < C; i++)
            chunk_pop = chunk_pop + CNT_W'(out_data[i]);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            k    <= '0;
            p    <= '0;
            card <= '0;
            done <= 1'b0;
        end else begin
            done <= 1'b0;
            if (run_go) begin
                k    <= '0;
                p    <= '0;
                card <= '0;
            end else if (in_xfer) begin
                if (k_last) begin
                    k <= '0;
                    p <= p_last ? '0 : p + 1'b1;
                end else begin
                    k <= k + 1'b1;
                end
            end else if (out_hs) begin
                card <= card + chunk_pop;
                k    <= k_last ? '0 : k + 1'b1;
                done <= k_last;
            end
        end
    end

    // party 0 overwrites, so no clear is needed between runs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int j = 0; j < K; j++) acc[j] <= '0;
        end else if (in_xfer) begin
            for (int j = 0; j < K; j++)
                if (k == KW'(j))
                    acc[j] <= (p == '0) ? in_data : (acc[j] & in_data);
        end
    end
endmodule

// File: doc/psi_chunk_sched.md
# psi_chunk_sched

Sequencing controller for the bitmap private-set-intersection datapath. It streams each party's W-bit membership bitmap in C-bit chunks, folds the chunks into a W-bit AND accumulator, then streams out the intersection bitmap and its cardinality. It lets large N×W intersections run over a narrow input port instead of a full N*W-bit parallel bus.

## Interface
- N, 4, number of parties (≥2)
- W, 16, bitmap width in bits; W must be a multiple of C
- C, 4, chunk width in bits
- CNT_W, $clog2(W+1), cardinality counter width
- clk  in  1  rising-edge clock
- rst_n  in  1  reset, asynchronous, active-low
- start  in  1  begin a new intersection; honoured only in IDLE
- abort  in  1  cancel current run; return to IDLE next cycle
- in_valid  in  1  in_data holds a valid chunk
- in_ready  out  1  block accepts a chunk this cycle
- in_data  in  C  chunk k of party p, bit i = element k*C+i
- out_valid  out  1  out_data holds a valid result chunk
- out_ready  in  1  downstream accepts the result chunk
- out_data  out  C  result chunk, same bit mapping as in_data
- busy  out  1  high in LOAD or DRAIN
- done  out  1  one-cycle pulse when a run completes
- card  out  CNT_W  popcount of the intersection; valid from done until the next start

## Operation
- Reset values: state IDLE; in_ready, out_valid, busy and done are 0; card, out_data, accumulator and counters are 0.
- States: IDLE, LOAD, DRAIN.
- IDLE → LOAD on start. Clears the chunk index k, party index p and card. The accumulator is not cleared; it is overwritten by party 0.
- LOAD:
  - in_ready = 1. A transfer is in_valid & in_ready.
  - On a transfer with p==0, acc[k] ← in_data. With p>0, acc[k] ← acc[k] & in_data.
  - k increments per transfer. It wraps to 0 at W/C−1 and p increments at the same time.
  - The transfer with p==N−1 and k==W/C−1 moves the state to DRAIN with k=0.
- DRAIN:
  - out_valid = 1 and out_data = acc[k].
  - On out_valid & out_ready: card ← card + popcount(acc[k]) and k increments.
  - The handshake at k==W/C−1 moves the state to IDLE and asserts done for the following cycle. card then holds its final value.
- card arithmetic is unsigned. The maximum is W, so it never overflows CNT_W.
- The input side is party-major: all chunks of party 0, then all chunks of party 1, and so on. Order inside a party is k ascending.
- start while busy is ignored.
- abort has priority over every transfer in the same cycle:
  - the chunk is not accepted, or the output chunk is not counted;
  - the state goes to IDLE and done stays 0;
  - card and acc keep their partial values and carry no meaning.
- Async reset mid-run returns to the reset values immediately; no done is produced.
- in_valid is ignored outside LOAD. out_ready is ignored outside DRAIN.

## Timing
- One input chunk is accepted per cycle at most. With in_valid held high, LOAD lasts exactly N*W/C cycles.
- out_valid rises on the first cycle after the last input transfer.
- With out_ready held high, DRAIN lasts exactly W/C cycles.
- done rises on the cycle after the last output handshake.
- Minimum start-to-done latency: 1 + N*W/C + W/C cycles. The next start is accepted on the done cycle.
- Backpressure stalls:
  - in_valid low during LOAD holds p, k and acc.
  - out_ready low during DRAIN holds out_data stable and out_valid high.
- in_ready and out_valid are decoded from registered state. They do not depend combinationally on in_valid or out_ready.

## Test plan
- Nominal (N=4, W=16, C=4): parties 0xFFFF, 0xF0F0, 0xFF00, 0xA5FF with in_valid and out_ready held high → out chunks 0x0, 0x0, 0x0, 0xA (k order), card=2, done exactly 21 cycles after start.
- Disjoint and identical sets: all parties 0x1234 → output 0x4, 0x3, 0x2, 0x1 in k order and card=5. One party 0x0000 → all chunks 0 and card=0.
- Random in_valid and out_ready stalls (50%) with random bitmaps → output equals the bitwise AND reference; out_data is stable while stalled; no chunk is lost or duplicated.
- abort asserted in the same cycle as the 7th input transfer → that chunk is not accepted, IDLE next cycle, no done. A following clean run gives the correct result.
- start pulsed during LOAD and DRAIN → ignored, run result unchanged. start on the done cycle → the new run begins and card clears.
- rst_n dropped asynchronously mid-DRAIN → all outputs are 0 before the next clock edge; the next full run is correct.
